// File: rtl/doctor_allocator_n_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : doctor_allocator_n_pkg
//  Purpose  : Shared query and response encodings for the reception-desk
//             doctor allocator.
//  Revision : 1.0  initial release
// ============================================================================
package doctor_allocator_n_pkg;

   // Query codes on i_query; any code with bit 1 set is reserved and ignored.
   localparam logic [1:0] Q_GENERAL   = 2'b00;
   localparam logic [1:0] Q_EMERGENCY = 2'b01;

   // Response codes on o_resp_code.
   localparam logic [1:0] R_NONE      = 2'b00;
   localparam logic [1:0] R_ALLOT     = 2'b01;
   localparam logic [1:0] R_WAIT      = 2'b10;
   localparam logic [1:0] R_REJECT    = 2'b11;

endpackage
`default_nettype wire

// File: rtl/doctor_allocator_n_if.sv
`default_nettype none
// ============================================================================
//  Module   : doctor_allocator_n_if
//  Purpose  : Bundles the front-desk query strobe with the response, call,
//             busy and queue-occupancy outputs of the allocator.
//  Ports    : i_start/i_query        query source -> allocator
//             o_resp_*               response to a sampled query
//             o_call_*               queued patient called to a doctor
//             o_busy, o_queue_count  status for the display logic
//  Modports : master = query source / display side, slave = allocator
//  Revision : 1.0  initial release
// ============================================================================
interface doctor_allocator_n_if #(
   parameter int N_DOCTORS   = 2,
   parameter int QUEUE_DEPTH = 4,
   parameter int TICKET_W    = 4
);
   localparam int DOC_W = (N_DOCTORS > 1) ? $clog2(N_DOCTORS) : 1;
   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

   logic                 i_start;
   logic [1:0]           i_query;
   logic                 o_resp_valid;
   logic [1:0]           o_resp_code;
   logic [DOC_W-1:0]     o_resp_doctor;
   logic [TICKET_W-1:0]  o_resp_ticket;
   logic                 o_call_valid;
   logic [DOC_W-1:0]     o_call_doctor;
   logic [TICKET_W-1:0]  o_call_ticket;
   logic [N_DOCTORS-1:0] o_busy;
   logic [CNT_W-1:0]     o_queue_count;

   modport master (
      output i_start, i_query,
      input  o_resp_valid, o_resp_code, o_resp_doctor, o_resp_ticket,
      input  o_call_valid, o_call_doctor, o_call_ticket, o_busy, o_queue_count
   );

   modport slave (
      input  i_start, i_query,
      output o_resp_valid, o_resp_code, o_resp_doctor, o_resp_ticket,
      output o_call_valid, o_call_doctor, o_call_ticket, o_busy, o_queue_count
   );
endinterface
`default_nettype wire

// File: rtl/doctor_allocator_n_consult_timer.sv
`default_nettype none
// ============================================================================
//  Module   : consult_timer
//  Purpose  : Per-doctor consultation timer. A load starts a countdown of
//             CONSULT_CYCLES; o_busy is high for exactly CONSULT_CYCLES
//             cycles beginning in the cycle after the load edge.
//  Ports    : clk, reset (sync, active-high), i_load, o_busy
//  Revision : 1.0  initial release
// ============================================================================
module consult_timer #(
   parameter int CONSULT_CYCLES = 15
) (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic i_load,
   output logic      o_busy
);
   localparam int TMR_W = $clog2(CONSULT_CYCLES + 1);

   logic [TMR_W-1:0] r_cnt;
   logic             r_busy;

   // r_busy mirrors (r_cnt != 0) but is kept as its own flop so the
   // output comes straight from a register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_load) begin
         r_cnt  <= TMR_W'(CONSULT_CYCLES);
         r_busy <= 1'b1;
      end else if (r_cnt != '0) begin
         r_cnt  <= r_cnt - 1'b1;
         r_busy <= (r_cnt != TMR_W'(1));
      end
   end

   assign o_busy = r_busy;
endmodule
`default_nettype wire

// File: rtl/doctor_allocator_n.sv
`default_nettype none
// ============================================================================
//  Module   : doctor_allocator_n
//  Purpose  : Reception-desk allocator. Each sampled query is allotted to the
//             lowest-index free doctor, queued with a ticket, or rejected.
//             When a doctor frees up the queue head is called automatically;
//             emergencies are inserted at the queue head.
//  Ports    : clk, reset (sync, active-high), bus (slave modport: query in,
//             response/call pulses, busy vector, queue occupancy out)
//  Revision : 1.0  initial release
// ============================================================================
module doctor_allocator_n
   import doctor_allocator_n_pkg::*;
#(
   parameter int N_DOCTORS      = 2,
   parameter int CONSULT_CYCLES = 15,
   parameter int QUEUE_DEPTH    = 4,
   parameter int TICKET_W       = 4
) (
   input wire logic             clk,
   input wire logic             reset,
   doctor_allocator_n_if.slave  bus
);
   localparam int DOC_W = (N_DOCTORS > 1) ? $clog2(N_DOCTORS) : 1;
   localparam int QP_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

   // Pointer arithmetic wraps explicitly so non-power-of-2 depths work.
   function automatic logic [QP_W-1:0] ptr_inc(input logic [QP_W-1:0] p);
      return (p == QP_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [QP_W-1:0] ptr_dec(input logic [QP_W-1:0] p);
      return (p == '0) ? QP_W'(QUEUE_DEPTH - 1) : p - 1'b1;
   endfunction

   logic [N_DOCTORS-1:0] w_busy;
   logic [N_DOCTORS-1:0] w_load;

   generate
      for (genvar gi = 0; gi < N_DOCTORS; gi++) begin : g_doc
         consult_timer #(.CONSULT_CYCLES(CONSULT_CYCLES)) u_timer (
            .clk    (clk),
            .reset  (reset),
            .i_load (w_load[gi]),
            .o_busy (w_busy[gi])
         );
      end
   endgenerate

   logic [TICKET_W-1:0] r_q [QUEUE_DEPTH];
   logic [QP_W-1:0]     r_head, r_tail;
   logic [CNT_W-1:0]    r_count;
   logic [TICKET_W-1:0] r_ticket;

   logic                r_resp_valid, r_call_valid;
   logic [1:0]          r_resp_code;
   logic [DOC_W-1:0]    r_resp_doctor, r_call_doctor;
   logic [TICKET_W-1:0] r_resp_ticket, r_call_ticket;

   logic                w_any_free, w_pop, w_query_ok, w_allot, w_push, w_emerg;
   logic [DOC_W-1:0]    w_low_doc;
   logic [CNT_W-1:0]    w_count_post;
   logic [QP_W-1:0]     w_head_post, w_head_next, w_tail_next, w_wr_idx;

   always_comb begin
      w_any_free = 1'b0;
      w_low_doc  = '0;
      // Scan downwards so the last hit is the lowest free index.
      for (int i = N_DOCTORS - 1; i >= 0; i--) begin
         if (!w_busy[i]) begin
            w_any_free = 1'b1;
            w_low_doc  = DOC_W'(i);
         end
      end

      w_pop      = (r_count != '0) && w_any_free;
      w_query_ok = bus.i_start && !bus.i_query[1];
      w_emerg    = bus.i_query[0];
      // Allotment only with an empty queue, so a pop never competes for the
      // same doctor in that cycle.
      w_allot    = w_query_ok && (r_count == '0) && w_any_free;
      // Occupancy is judged after this cycle's pop.
      w_count_post = r_count - CNT_W'(w_pop);
      w_push     = w_query_ok && !w_allot && (w_count_post != CNT_W'(QUEUE_DEPTH));

      w_head_post = w_pop ? ptr_inc(r_head) : r_head;
      w_head_next = w_head_post;
      w_tail_next = r_tail;
      w_wr_idx    = r_tail;
      if (w_push) begin
         if (w_emerg) begin
            w_head_next = ptr_dec(w_head_post);
            w_wr_idx    = w_head_next;
         end else begin
            w_tail_next = ptr_inc(r_tail);
         end
      end

      for (int i = 0; i < N_DOCTORS; i++) begin
         w_load[i] = (w_pop || w_allot) && (w_low_doc == DOC_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) r_q[i] <= '0;
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_ticket      <= '0;
         r_resp_valid  <= 1'b0;
         r_resp_code   <= R_NONE;
         r_resp_doctor <= '0;
         r_resp_ticket <= '0;
         r_call_valid  <= 1'b0;
         r_call_doctor <= '0;
         r_call_ticket <= '0;
      end else begin
         r_resp_valid  <= w_query_ok;
         r_resp_code   <= w_allot ? R_ALLOT : w_push ? R_WAIT :
                          w_query_ok ? R_REJECT : R_NONE;
         r_resp_doctor <= w_allot ? w_low_doc : '0;
         r_resp_ticket <= (w_allot || w_push) ? r_ticket : '0;

         r_call_valid  <= w_pop;
         r_call_doctor <= w_pop ? w_low_doc : '0;
         r_call_ticket <= w_pop ? r_q[r_head] : '0;

         if (w_allot || w_push) r_ticket <= r_ticket + 1'b1;
         if (w_push)            r_q[w_wr_idx] <= r_ticket;
         r_head  <= w_head_next;
         r_tail  <= w_tail_next;
         r_count <= w_count_post + CNT_W'(w_push);
      end
   end

   assign bus.o_resp_valid  = r_resp_valid;
   assign bus.o_resp_code   = r_resp_code;
   assign bus.o_resp_doctor = r_resp_doctor;
   assign bus.o_resp_ticket = r_resp_ticket;
   assign bus.o_call_valid  = r_call_valid;
   assign bus.o_call_doctor = r_call_doctor;
   assign bus.o_call_ticket = r_call_ticket;
   assign bus.o_busy        = w_busy;
   assign bus.o_queue_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_doctor_allocator_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_doctor_allocator_n
//  Purpose  : Self-checking bench for doctor_allocator_n against a
//             queue-based behavioural model of the reception desk.
//  Revision : 1.0  initial release
// ============================================================================
module tb_doctor_allocator_n;
   localparam int N  = 2;
   localparam int C  = 15;
   localparam int D  = 4;
   localparam int TW = 4;

   logic clk = 1'b0;
   logic reset;
   always #10 clk = ~clk;

   doctor_allocator_n_if #(.N_DOCTORS(N), .QUEUE_DEPTH(D), .TICKET_W(TW)) bus ();

   doctor_allocator_n #(
      .N_DOCTORS(N), .CONSULT_CYCLES(C), .QUEUE_DEPTH(D), .TICKET_W(TW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: remaining consultation time per doctor, FIFO of tickets
   int m_timer [N];
   int m_q [$];
   int m_ticket;

   int e_rv, e_rc, e_rd, e_rt, e_cv, e_cd, e_ct, e_qc;
   logic [N-1:0] e_busy;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_timer[i] = 0;
      m_q.delete();
      m_ticket = 0;
   endtask

   task automatic model_step(input logic st, input logic [1:0] q);
      bit loaded [N];
      int pre, first, j;
      for (int i = 0; i < N; i++) loaded[i] = 0;
      pre   = m_q.size();
      first = -1;
      for (int i = 0; i < N; i++) if (m_timer[i] == 0 && first < 0) first = i;
      e_rv = 0; e_rc = 0; e_rd = 0; e_rt = 0; e_cv = 0; e_cd = 0; e_ct = 0;

      if (pre > 0 && first >= 0) begin
         e_cv = 1; e_cd = first; e_ct = m_q.pop_front(); loaded[first] = 1;
      end

      if (st && q < 2) begin
         e_rv = 1;
         j = -1;
         for (int i = 0; i < N; i++) if (m_timer[i] == 0 && !loaded[i] && j < 0) j = i;
         if (pre == 0 && j >= 0) begin
            e_rc = 1; e_rd = j; e_rt = m_ticket; loaded[j] = 1;
            m_ticket = (m_ticket + 1) % (1 << TW);
         end else if (m_q.size() < D) begin
            e_rc = 2; e_rt = m_ticket;
            if (q == 2'b01) m_q.push_front(m_ticket);
            else            m_q.push_back(m_ticket);
            m_ticket = (m_ticket + 1) % (1 << TW);
         end else begin
            e_rc = 3;
         end
      end

      for (int i = 0; i < N; i++) begin
         if (loaded[i])          m_timer[i] = C;
         else if (m_timer[i] > 0) m_timer[i] = m_timer[i] - 1;
         e_busy[i] = (m_timer[i] != 0);
      end
      e_qc = m_q.size();
   endtask

   task automatic cycle(input logic st, input logic [1:0] q);
      bus.i_start = st;
      bus.i_query = q;
      model_step(st, q);
      @(posedge clk); #1;
      chk("resp_valid", 32'(bus.o_resp_valid), 32'(e_rv));
      if (e_rv != 0) begin
         chk("resp_code",   32'(bus.o_resp_code),   32'(e_rc));
         chk("resp_doctor", 32'(bus.o_resp_doctor), 32'(e_rd));
         chk("resp_ticket", 32'(bus.o_resp_ticket), 32'(e_rt));
      end
      chk("call_valid", 32'(bus.o_call_valid), 32'(e_cv));
      if (e_cv != 0) begin
         chk("call_doctor", 32'(bus.o_call_doctor), 32'(e_cd));
         chk("call_ticket", 32'(bus.o_call_ticket), 32'(e_ct));
      end
      chk("busy",        32'(bus.o_busy),        32'(e_busy));
      chk("queue_count", 32'(bus.o_queue_count), 32'(e_qc));
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      bus.i_start = 1'b0;
      bus.i_query = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      chk("rst_resp_valid",  32'(bus.o_resp_valid),  0);
      chk("rst_resp_code",   32'(bus.o_resp_code),   0);
      chk("rst_resp_ticket", 32'(bus.o_resp_ticket), 0);
      chk("rst_call_valid",  32'(bus.o_call_valid),  0);
      chk("rst_busy",        32'(bus.o_busy),        0);
      chk("rst_queue_count", 32'(bus.o_queue_count), 0);
      reset = 1'b0;
   endtask

   task automatic rand_cycle();
      int r;
      logic [1:0] q;
      r = int'($urandom_range(0, 99));
      if (r < 55)      q = 2'b00;
      else if (r < 85) q = 2'b01;
      else             q = 2'($urandom_range(2, 3));
      cycle($urandom_range(0, 99) < 65, q);
   endtask

   initial begin
      do_reset();

      // Three consecutive general queries: two allotments then one wait.
      cycle(1'b1, 2'b00);
      chk("t1_code0", 32'(bus.o_resp_code), 1);
      chk("t1_doc0",  32'(bus.o_resp_doctor), 0);
      chk("t1_tick0", 32'(bus.o_resp_ticket), 0);
      cycle(1'b1, 2'b00);
      chk("t1_code1", 32'(bus.o_resp_code), 1);
      chk("t1_doc1",  32'(bus.o_resp_doctor), 1);
      chk("t1_tick1", 32'(bus.o_resp_ticket), 1);
      cycle(1'b1, 2'b00);
      chk("t1_code2", 32'(bus.o_resp_code), 2);
      chk("t1_tick2", 32'(bus.o_resp_ticket), 2);
      chk("t1_qcnt",  32'(bus.o_queue_count), 1);

      // Doctor 0 was allotted two cycles ago; it frees after 15 busy cycles
      // and the waiting ticket 2 is called one cycle later.
      repeat (14) cycle(1'b0, 2'b00);
      chk("t2_call_valid",  32'(bus.o_call_valid), 1);
      chk("t2_call_doctor", 32'(bus.o_call_doctor), 0);
      chk("t2_call_ticket", 32'(bus.o_call_ticket), 2);
      chk("t2_busy0",       32'(bus.o_busy[0]), 1);
      chk("t2_qcnt",        32'(bus.o_queue_count), 0);

      // Reserved query: no response.
      cycle(1'b1, 2'b10);
      chk("t5_reserved", 32'(bus.o_resp_valid), 0);

      // Randomized traffic with periodic mid-operation resets.
      for (int blk = 0; blk < 4; blk++) begin
         repeat (300) rand_cycle();
         do_reset();
         repeat (C + 5) cycle(1'b0, 2'b00);
      end

      // Heavy emergency load to exercise head insertion and full-queue pops.
      repeat (300) cycle($urandom_range(0, 9) < 8, 2'($urandom_range(0, 1)));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
